// File: rtl/apmu_ibex_wb_queue.sv
// apmu_ibex_wb_queue: in-order writeback queue between ID/EX and the register file.
// Entries retire from the head: OTHER entries as soon as they reach it, LOAD/STORE
// entries on the LSU response. The single RF write port is shared between the LSU,
// the head entry and a set of auxiliary writers. A small starvation counter keeps
// a steady stream of OTHER writes from locking out the auxiliary writers.
// Optional feature: define APMU_WB_FWD_EN to forward queued non-load results to the
// ID operands instead of stalling on them.

package apmu_ibex_wb_pkg;
    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;
endpackage

module apmu_ibex_wb_queue
    import apmu_ibex_wb_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned NUM_AUX = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         en_wb_i,
    output logic                         ready_wb_o,
    input  wb_instr_type_e               instr_type_wb_i,
    input  logic [31:0]                  pc_id_i,
    input  logic                         instr_is_compressed_id_i,
    input  logic                         instr_perf_count_id_i,

    input  logic [4:0]                   rf_waddr_id_i,
    input  logic [31:0]                  rf_wdata_id_i,
    input  logic                         rf_we_id_i,

    input  logic [31:0]                  rf_wdata_lsu_i,
    input  logic                         rf_we_lsu_i,
    input  logic                         lsu_resp_valid_i,
    input  logic                         lsu_resp_err_i,

    input  logic [NUM_AUX-1:0]           aux_req_i,
    input  logic [5*NUM_AUX-1:0]         aux_waddr_i,
    input  logic [32*NUM_AUX-1:0]        aux_wdata_i,
    output logic [NUM_AUX-1:0]           aux_gnt_o,

    input  logic [4:0]                   rf_raddr_a_i,
    input  logic [4:0]                   rf_raddr_b_i,
    output logic [1:0]                   rf_hazard_o,
    output logic [1:0]                   rf_fwd_valid_o,
    output logic [31:0]                  rf_fwd_a_o,
    output logic [31:0]                  rf_fwd_b_o,

    output logic [4:0]                   rf_waddr_wb_o,
    output logic [31:0]                  rf_wdata_wb_o,
    output logic                         rf_we_wb_o,

    output logic [31:0]                  pc_wb_o,
    output logic                         instr_done_wb_o,
    output logic                         outstanding_load_wb_o,
    output logic                         outstanding_store_wb_o,
    output logic                         perf_instr_ret_wb_o,
    output logic                         perf_instr_ret_compressed_wb_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AUX_W = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    wb_instr_type_e type_q  [DEPTH];
    logic [31:0]    pc_q    [DEPTH];
    logic           compr_q [DEPTH];
    logic           perf_q  [DEPTH];
    logic [4:0]     waddr_q [DEPTH];
    logic [31:0]    wdata_q [DEPTH];
    logic           we_q    [DEPTH];

    ptr_t       rd_ptr_q;
    ptr_t       wr_ptr_q;
    cnt_t       count_q;
    logic [1:0] starve_q;

    cnt_t           count_eff;
    wb_instr_type_e head_type;
    logic           head_valid;
    logic           head_other;
    logic           head_lsu;
    logic           head_wr;
    logic           head_done;
    logic           aux_any;
    logic           aux_hit;
    logic           aux_preempt;
    logic           lsu_wr;
    logic [NUM_AUX-1:0] aux_onehot;
    logic [4:0]     aux_addr;
    logic [31:0]    aux_data;
    logic           push;
    logic           retire;

    logic           found_a;
    logic           found_b;
`ifdef APMU_WB_FWD_EN
    logic           load_a;
    logic           load_b;
    logic [31:0]    data_a;
    logic [31:0]    data_b;
`endif

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Reset hides the stored entries immediately, so every output is quiet while rst_i is high.
    assign count_eff   = rst_i ? '0 : count_q;
    assign occupancy_o = count_eff;

    // Head status, retire decision and lowest-index auxiliary request selection.
    always_comb begin
        head_valid  = (count_eff != '0);
        head_type   = type_q[rd_ptr_q];
        head_other  = head_valid && (head_type == WB_INSTR_OTHER);
        head_lsu    = head_valid && (head_type != WB_INSTR_OTHER);
        head_wr     = head_other && we_q[rd_ptr_q];
        aux_any     = !rst_i && (|aux_req_i);
        // A starved aux writer takes the port from a head OTHER write; that head waits a cycle.
        aux_preempt = head_wr && aux_any && (starve_q == 2'd3);
        lsu_wr      = head_lsu && lsu_resp_valid_i && rf_we_lsu_i;
        head_done   = head_other ? !aux_preempt : (head_lsu && lsu_resp_valid_i);

        aux_hit    = 1'b0;
        aux_onehot = '0;
        aux_addr   = '0;
        aux_data   = '0;
        for (int unsigned j = 0; j < NUM_AUX; j++) begin
            if (aux_req_i[AUX_W'(j)] && !aux_hit) begin
                aux_hit    = 1'b1;
                aux_onehot = NUM_AUX'(1) << j;
                aux_addr   = 5'(aux_waddr_i >> (5 * j));
                aux_data   = 32'(aux_wdata_i >> (32 * j));
            end
        end
    end

    // Single RF write port: LSU response, then head OTHER write, then auxiliary writer.
    always_comb begin
        rf_we_wb_o    = 1'b0;
        rf_waddr_wb_o = '0;
        rf_wdata_wb_o = '0;
        aux_gnt_o     = '0;
        if (lsu_wr) begin
            rf_we_wb_o    = 1'b1;
            rf_waddr_wb_o = waddr_q[rd_ptr_q];
            rf_wdata_wb_o = rf_wdata_lsu_i;
        end else if (head_wr && !aux_preempt) begin
            rf_we_wb_o    = 1'b1;
            rf_waddr_wb_o = waddr_q[rd_ptr_q];
            rf_wdata_wb_o = wdata_q[rd_ptr_q];
        end else if (aux_any) begin
            rf_we_wb_o    = 1'b1;
            rf_waddr_wb_o = aux_addr;
            rf_wdata_wb_o = aux_data;
            aux_gnt_o     = aux_onehot;
        end
    end

    // Handshake and retire strobes.
    always_comb begin
        retire                         = head_done;
        ready_wb_o                     = (count_eff < cnt_t'(DEPTH)) || head_done;
        push                           = !rst_i && en_wb_i && ready_wb_o;
        instr_done_wb_o                = head_done;
        perf_instr_ret_wb_o            = head_done && perf_q[rd_ptr_q]
                                         && !(lsu_resp_valid_i && lsu_resp_err_i);
        perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o && compr_q[rd_ptr_q];
        pc_wb_o                        = head_valid ? pc_q[rd_ptr_q] : '0;
    end

    // Walk valid entries oldest to youngest so the last match recorded is the youngest.
    always_comb begin
        int unsigned k;
        ptr_t        idx;
        logic        wr_like;
        k                      = 0;
        idx                    = '0;
        wr_like                = 1'b0;
        found_a                = 1'b0;
        found_b                = 1'b0;
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
`ifdef APMU_WB_FWD_EN
        load_a = 1'b0;
        load_b = 1'b0;
        data_a = '0;
        data_b = '0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            k = 32'(rd_ptr_q) + i;
            if (k >= DEPTH) begin
                k = k - DEPTH;
            end
            idx = ptr_t'(k);
            if (cnt_t'(i) < count_eff) begin
                if (type_q[idx] == WB_INSTR_LOAD) begin
                    outstanding_load_wb_o = 1'b1;
                end
                if (type_q[idx] == WB_INSTR_STORE) begin
                    outstanding_store_wb_o = 1'b1;
                end
                wr_like = we_q[idx] || (type_q[idx] == WB_INSTR_LOAD);
                if (wr_like && (waddr_q[idx] == rf_raddr_a_i) && (rf_raddr_a_i != '0)) begin
                    found_a = 1'b1;
`ifdef APMU_WB_FWD_EN
                    load_a  = (type_q[idx] == WB_INSTR_LOAD);
                    data_a  = wdata_q[idx];
`endif
                end
                if (wr_like && (waddr_q[idx] == rf_raddr_b_i) && (rf_raddr_b_i != '0)) begin
                    found_b = 1'b1;
`ifdef APMU_WB_FWD_EN
                    load_b  = (type_q[idx] == WB_INSTR_LOAD);
                    data_b  = wdata_q[idx];
`endif
                end
            end
        end
    end

    // Operand hazard / forward decision from the youngest match.
    always_comb begin
`ifdef APMU_WB_FWD_EN
        rf_hazard_o    = {found_b && load_b, found_a && load_a};
        rf_fwd_valid_o = {found_b && !load_b, found_a && !load_a};
        rf_fwd_a_o     = (found_a && !load_a) ? data_a : '0;
        rf_fwd_b_o     = (found_b && !load_b) ? data_b : '0;
`else
        rf_hazard_o    = {found_b, found_a};
        rf_fwd_valid_o = '0;
        rf_fwd_a_o     = '0;
        rf_fwd_b_o     = '0;
`endif
    end

    // Pointer, occupancy and starvation bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (retire) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, retire})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
            if (|aux_gnt_o) begin
                starve_q <= '0;
            end else if (aux_any && (starve_q != 2'd3)) begin
                starve_q <= starve_q + 2'd1;
            end
        end
    end

    // Entry payload; no reset needed because the occupancy count qualifies every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            type_q[wr_ptr_q]  <= instr_type_wb_i;
            pc_q[wr_ptr_q]    <= pc_id_i;
            compr_q[wr_ptr_q] <= instr_is_compressed_id_i;
            perf_q[wr_ptr_q]  <= instr_perf_count_id_i;
            waddr_q[wr_ptr_q] <= rf_waddr_id_i;
            wdata_q[wr_ptr_q] <= rf_wdata_id_i;
            we_q[wr_ptr_q]    <= rf_we_id_i;
        end
    end

endmodule

// File: tb/tb_apmu_ibex_wb_queue.sv
// Randomized bench for apmu_ibex_wb_queue against a queue-based reference model.
module tb_apmu_ibex_wb_queue;
    import apmu_ibex_wb_pkg::*;

    localparam int DEPTH   = 3;
    localparam int NUM_AUX = 2;
    localparam int CW      = $clog2(DEPTH + 1);

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                   rst_i;
    logic                   en_wb_i;
    logic                   ready_wb_o;
    wb_instr_type_e         instr_type_wb_i;
    logic [31:0]            pc_id_i;
    logic                   instr_is_compressed_id_i;
    logic                   instr_perf_count_id_i;
    logic [4:0]             rf_waddr_id_i;
    logic [31:0]            rf_wdata_id_i;
    logic                   rf_we_id_i;
    logic [31:0]            rf_wdata_lsu_i;
    logic                   rf_we_lsu_i;
    logic                   lsu_resp_valid_i;
    logic                   lsu_resp_err_i;
    logic [NUM_AUX-1:0]     aux_req_i;
    logic [5*NUM_AUX-1:0]   aux_waddr_i;
    logic [32*NUM_AUX-1:0]  aux_wdata_i;
    logic [NUM_AUX-1:0]     aux_gnt_o;
    logic [4:0]             rf_raddr_a_i;
    logic [4:0]             rf_raddr_b_i;
    logic [1:0]             rf_hazard_o;
    logic [1:0]             rf_fwd_valid_o;
    logic [31:0]            rf_fwd_a_o;
    logic [31:0]            rf_fwd_b_o;
    logic [4:0]             rf_waddr_wb_o;
    logic [31:0]            rf_wdata_wb_o;
    logic                   rf_we_wb_o;
    logic [31:0]            pc_wb_o;
    logic                   instr_done_wb_o;
    logic                   outstanding_load_wb_o;
    logic                   outstanding_store_wb_o;
    logic                   perf_instr_ret_wb_o;
    logic                   perf_instr_ret_compressed_wb_o;
    logic [CW-1:0]          occupancy_o;

    apmu_ibex_wb_queue #(.DEPTH(DEPTH), .NUM_AUX(NUM_AUX)) dut (
        .clk_i                          (clk_i),
        .rst_i                          (rst_i),
        .en_wb_i                        (en_wb_i),
        .ready_wb_o                     (ready_wb_o),
        .instr_type_wb_i                (instr_type_wb_i),
        .pc_id_i                        (pc_id_i),
        .instr_is_compressed_id_i       (instr_is_compressed_id_i),
        .instr_perf_count_id_i          (instr_perf_count_id_i),
        .rf_waddr_id_i                  (rf_waddr_id_i),
        .rf_wdata_id_i                  (rf_wdata_id_i),
        .rf_we_id_i                     (rf_we_id_i),
        .rf_wdata_lsu_i                 (rf_wdata_lsu_i),
        .rf_we_lsu_i                    (rf_we_lsu_i),
        .lsu_resp_valid_i               (lsu_resp_valid_i),
        .lsu_resp_err_i                 (lsu_resp_err_i),
        .aux_req_i                      (aux_req_i),
        .aux_waddr_i                    (aux_waddr_i),
        .aux_wdata_i                    (aux_wdata_i),
        .aux_gnt_o                      (aux_gnt_o),
        .rf_raddr_a_i                   (rf_raddr_a_i),
        .rf_raddr_b_i                   (rf_raddr_b_i),
        .rf_hazard_o                    (rf_hazard_o),
        .rf_fwd_valid_o                 (rf_fwd_valid_o),
        .rf_fwd_a_o                     (rf_fwd_a_o),
        .rf_fwd_b_o                     (rf_fwd_b_o),
        .rf_waddr_wb_o                  (rf_waddr_wb_o),
        .rf_wdata_wb_o                  (rf_wdata_wb_o),
        .rf_we_wb_o                     (rf_we_wb_o),
        .pc_wb_o                        (pc_wb_o),
        .instr_done_wb_o                (instr_done_wb_o),
        .outstanding_load_wb_o          (outstanding_load_wb_o),
        .outstanding_store_wb_o         (outstanding_store_wb_o),
        .perf_instr_ret_wb_o            (perf_instr_ret_wb_o),
        .perf_instr_ret_compressed_wb_o (perf_instr_ret_compressed_wb_o),
        .occupancy_o                    (occupancy_o)
    );

    typedef struct {
        wb_instr_type_e t;
        logic [31:0]    pc;
        logic           cmp;
        logic           perf;
        logic [4:0]     waddr;
        logic [31:0]    wdata;
        logic           we;
    } ent_t;

    ent_t        q[$];
    int          starve;
    logic [NUM_AUX-1:0] aux_pend;
    logic [4:0]  aux_a [NUM_AUX];
    logic [31:0] aux_d [NUM_AUX];
    int          n_cmp;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Youngest queued writer of ra decides: stall on a load, otherwise forward (or stall without forwarding).
    function automatic void hz(input logic [4:0] ra, output logic h, output logic fv,
                               output logic [31:0] fd);
        h  = 1'b0;
        fv = 1'b0;
        fd = '0;
        if (ra != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if ((q[i].we || q[i].t == WB_INSTR_LOAD) && q[i].waddr == ra) begin
`ifdef APMU_WB_FWD_EN
                    if (q[i].t == WB_INSTR_LOAD) h = 1'b1;
                    else begin
                        fv = 1'b1;
                        fd = q[i].wdata;
                    end
`else
                    h = 1'b1;
`endif
                    break;
                end
            end
        end
    endfunction

    task automatic run_cycle(input int mode, input bit force_rst);
        ent_t        h;
        ent_t        n;
        bit          hv, aux_any, lsu_wr, head_w, pre;
        int          aj;
        logic        e_we, e_done, e_perf, e_cmp, e_ready, e_ol, e_os;
        logic [4:0]  e_addr;
        logic [31:0] e_data, e_pc;
        logic [NUM_AUX-1:0] e_gnt;
        logic        ha, hb, fva, fvb;
        logic [31:0] fda, fdb;

        @(negedge clk_i);
        rst_i   = force_rst || ($urandom_range(0, 299) == 0);
        en_wb_i = ($urandom_range(0, 3) != 0);
        case (mode)
            1: begin
                instr_type_wb_i = ($urandom_range(0, 5) == 0) ? WB_INSTR_LOAD : WB_INSTR_OTHER;
                rf_we_id_i      = 1'b1;
            end
            2: begin
                instr_type_wb_i = ($urandom_range(0, 3) == 0) ? WB_INSTR_STORE : WB_INSTR_LOAD;
                rf_we_id_i      = 1'($urandom_range(0, 1));
            end
            default: begin
                case ($urandom_range(0, 2))
                    0:       instr_type_wb_i = WB_INSTR_LOAD;
                    1:       instr_type_wb_i = WB_INSTR_STORE;
                    default: instr_type_wb_i = WB_INSTR_OTHER;
                endcase
                rf_we_id_i = 1'($urandom_range(0, 1));
            end
        endcase
        pc_id_i                  = $urandom;
        instr_is_compressed_id_i = 1'($urandom_range(0, 1));
        instr_perf_count_id_i    = ($urandom_range(0, 3) != 0);
        rf_waddr_id_i            = 5'($urandom_range(0, 7));
        rf_wdata_id_i            = $urandom;
        lsu_resp_valid_i         = (mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
        rf_we_lsu_i              = 1'($urandom_range(0, 1));
        rf_wdata_lsu_i           = $urandom;
        lsu_resp_err_i           = ($urandom_range(0, 3) == 0);
        for (int j = 0; j < NUM_AUX; j++) begin
            if (!aux_pend[j] && $urandom_range(0, (mode == 1) ? 1 : 5) == 0) begin
                aux_pend[j] = 1'b1;
                aux_a[j]    = 5'($urandom_range(1, 31));
                aux_d[j]    = $urandom;
            end
            aux_waddr_i[j*5 +: 5]   = aux_a[j];
            aux_wdata_i[j*32 +: 32] = aux_d[j];
        end
        aux_req_i    = aux_pend;
        rf_raddr_a_i = 5'($urandom_range(0, 7));
        rf_raddr_b_i = 5'($urandom_range(0, 7));
        #1;

        e_we = 0; e_addr = 0; e_data = 0; e_gnt = 0; e_done = 0; e_perf = 0; e_cmp = 0;
        e_ready = 1; e_ol = 0; e_os = 0; e_pc = 0;
        ha = 0; hb = 0; fva = 0; fvb = 0; fda = 0; fdb = 0;
        hv = (q.size() > 0) && !rst_i;
        if (hv) h = q[0];

        if (!rst_i) begin
            aux_any = (aux_req_i != '0);
            aj = 0;
            for (int j = NUM_AUX - 1; j >= 0; j--) if (aux_req_i[j]) aj = j;
            lsu_wr = hv && h.t != WB_INSTR_OTHER && lsu_resp_valid_i && rf_we_lsu_i;
            head_w = hv && h.t == WB_INSTR_OTHER && h.we;
            pre    = head_w && aux_any && starve == 3;
            e_done = hv && ((h.t == WB_INSTR_OTHER) ? !pre : lsu_resp_valid_i);
            if (lsu_wr) begin
                e_we = 1; e_addr = h.waddr; e_data = rf_wdata_lsu_i;
            end else if (head_w && !pre) begin
                e_we = 1; e_addr = h.waddr; e_data = h.wdata;
            end else if (aux_any) begin
                e_we = 1; e_addr = aux_a[aj]; e_data = aux_d[aj];
                e_gnt = NUM_AUX'(1) << aj;
            end
            e_perf  = e_done && h.perf && !(lsu_resp_valid_i && lsu_resp_err_i);
            e_cmp   = e_perf && h.cmp;
            e_ready = (q.size() < DEPTH) || e_done;
            foreach (q[i]) begin
                if (q[i].t == WB_INSTR_LOAD)  e_ol = 1;
                if (q[i].t == WB_INSTR_STORE) e_os = 1;
            end
            e_pc = hv ? h.pc : 32'd0;
            hz(rf_raddr_a_i, ha, fva, fda);
            hz(rf_raddr_b_i, hb, fvb, fdb);
        end

        chk("occupancy", 32'(occupancy_o), rst_i ? 32'd0 : 32'(q.size()));
        if (!rst_i) chk("ready", 32'(ready_wb_o), 32'(e_ready));
        chk("rf_we", 32'(rf_we_wb_o), 32'(e_we));
        if (e_we) begin
            chk("rf_waddr", 32'(rf_waddr_wb_o), 32'(e_addr));
            chk("rf_wdata", rf_wdata_wb_o, e_data);
        end
        chk("aux_gnt", 32'(aux_gnt_o), 32'(e_gnt));
        chk("instr_done", 32'(instr_done_wb_o), 32'(e_done));
        chk("perf_ret", 32'(perf_instr_ret_wb_o), 32'(e_perf));
        chk("perf_ret_c", 32'(perf_instr_ret_compressed_wb_o), 32'(e_cmp));
        chk("out_load", 32'(outstanding_load_wb_o), 32'(e_ol));
        chk("out_store", 32'(outstanding_store_wb_o), 32'(e_os));
        chk("pc_wb", pc_wb_o, e_pc);
        chk("hazard", 32'(rf_hazard_o), 32'({hb, ha}));
        chk("fwd_valid", 32'(rf_fwd_valid_o), 32'({fvb, fva}));
`ifdef APMU_WB_FWD_EN
        if (fva) chk("fwd_a", rf_fwd_a_o, fda);
        if (fvb) chk("fwd_b", rf_fwd_b_o, fdb);
`else
        chk("fwd_a", rf_fwd_a_o, 32'd0);
        chk("fwd_b", rf_fwd_b_o, 32'd0);
`endif

        if (rst_i) begin
            q.delete();
            starve = 0;
        end else begin
            if (e_done) void'(q.pop_front());
            if (en_wb_i && e_ready) begin
                n.t = instr_type_wb_i; n.pc = pc_id_i; n.cmp = instr_is_compressed_id_i;
                n.perf = instr_perf_count_id_i; n.waddr = rf_waddr_id_i;
                n.wdata = rf_wdata_id_i; n.we = rf_we_id_i;
                q.push_back(n);
            end
            if (e_gnt != '0) starve = 0;
            else if (aux_any && starve < 3) starve++;
            for (int j = 0; j < NUM_AUX; j++) if (e_gnt[j]) aux_pend[j] = 1'b0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        starve = 0;
        aux_pend = '0;
        for (int j = 0; j < NUM_AUX; j++) begin
            aux_a[j] = '0;
            aux_d[j] = '0;
        end
        rst_i = 1'b1; en_wb_i = 0; instr_type_wb_i = WB_INSTR_OTHER; pc_id_i = 0;
        instr_is_compressed_id_i = 0; instr_perf_count_id_i = 0; rf_waddr_id_i = 0;
        rf_wdata_id_i = 0; rf_we_id_i = 0; rf_wdata_lsu_i = 0; rf_we_lsu_i = 0;
        lsu_resp_valid_i = 0; lsu_resp_err_i = 0; aux_req_i = 0; aux_waddr_i = 0;
        aux_wdata_i = 0; rf_raddr_a_i = 0; rf_raddr_b_i = 0;

        repeat (3)    run_cycle(0, 1'b1);
        repeat (1000) run_cycle(1, 1'b0);
        repeat (1000) run_cycle(2, 1'b0);
        repeat (2000) run_cycle(0, 1'b0);
        repeat (2)    run_cycle(2, 1'b1);
        repeat (500)  run_cycle(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
